// File: rtl/bus_arb_pkg.sv
// Shared types for the two-master bus arbiter.
// FSM encoding, master indices and counter width.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int CW = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection.
// Purely combinational; pointer state lives in the caller.
module rr_arbiter2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = M0;
    unique case (1'b1)
      (req == 2'b11): grant = ~last;
      (req == 2'b10): grant = M1;
      default:        grant = M0;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter onto a single shared data bus.
// One access at a time: IDLE -> BUSY (LAT cycles) -> ACK.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          cpu_clk,
  input  logic          cpu_rst_n,
  input  logic          m0_req,
  input  logic          m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] bus_addr,
  output logic          bus_wen,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata
);

  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_gnt;
  logic          r_last;
  logic          r_wen;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_any;
  logic          w_gnt;
  logic          w_start;
  logic          w_last_busy;

  rr_arbiter2 u_rr (
    .req   ({m1_req, m0_req}),
    .last  (r_last),
    .grant (w_gnt)
  );

  assign w_any       = m0_req | m1_req;
  assign w_start     = (r_state == IDLE) && w_any;
  assign w_last_busy = (r_state == BUSY) && (r_cnt == ONE_C);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_next = BUSY;
      BUSY:    if (w_last_busy) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) r_state <= IDLE;
    else            r_state <= w_next;
  end

  // Request fields are latched once at grant; masters may drop req early.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_cnt   <= '0;
      r_gnt   <= M0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_start) begin
      r_cnt   <= LAT_C;
      r_gnt   <= w_gnt;
      r_wen   <= (w_gnt == M1) ? m1_wen   : m0_wen;
      r_addr  <= (w_gnt == M1) ? m1_addr  : m0_addr;
      r_wdata <= (w_gnt == M1) ? m1_wdata : m0_wdata;
    end else if (r_cnt != '0) begin
      r_cnt   <= r_cnt - ONE_C;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_last_busy && !r_wen) begin
      if (r_gnt == M1) r_rdata1 <= bus_rdata;
      else             r_rdata0 <= bus_rdata;
    end
  end

  // Reset value makes m0 win the first conflict.
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n)            r_last <= M1;
    else if (r_state == ACK)   r_last <= r_gnt;
  end

  assign m0_ack    = (r_state == ACK) && (r_gnt == M0);
  assign m1_ack    = (r_state == ACK) && (r_gnt == M1);
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign bus_wen   = (r_state == BUSY) && (r_cnt == LAT_C) && r_wen;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter, LAT=1 and LAT=3 instances.
// Directed table, hand sequences and random traffic vs a reference model.
module tb_bus_arbiter;

  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       req0, req1, wen0, wen1;
  logic [NI-1:0][31:0] addr0, addr1, wd0, wd1, brd;
  logic [NI-1:0]       ack0, ack1, bwen;
  logic [NI-1:0][31:0] rd0, rd1, baddr, bwd;

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    bus_arbiter #(
      .AW(32), .DW(32), .LAT((k == 0) ? 1 : 3)
    ) u_dut (
      .cpu_clk   (clk),
      .cpu_rst_n (rst_n),
      .m0_req    (req0[k]),
      .m0_wen    (wen0[k]),
      .m0_addr   (addr0[k]),
      .m0_wdata  (wd0[k]),
      .m0_ack    (ack0[k]),
      .m0_rdata  (rd0[k]),
      .m1_req    (req1[k]),
      .m1_wen    (wen1[k]),
      .m1_addr   (addr1[k]),
      .m1_wdata  (wd1[k]),
      .m1_ack    (ack1[k]),
      .m1_rdata  (rd1[k]),
      .bus_addr  (baddr[k]),
      .bus_wen   (bwen[k]),
      .bus_wdata (bwd[k]),
      .bus_rdata (brd[k])
    );
  end

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Reference model: phase 0 idle, 1 access in flight, 2 ack cycle.
  // m_e counts edges elapsed since the grant edge.
  int          m_ph[NI];
  int          m_e[NI];
  logic        m_g[NI], m_last[NI], m_wen[NI];
  logic [31:0] m_addr[NI], m_wd[NI], m_rd0[NI], m_rd1[NI];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_ph[k] = 0; m_e[k] = 0; m_g[k] = 1'b0; m_last[k] = 1'b1;
        m_wen[k] = 1'b0; m_addr[k] = '0; m_wd[k] = '0;
        m_rd0[k] = '0; m_rd1[k] = '0;
      end else if (m_ph[k] == 0) begin
        if (req0[k] || req1[k]) begin
          m_g[k]    = (req0[k] && req1[k]) ? !m_last[k] : req1[k];
          m_wen[k]  = m_g[k] ? wen1[k]  : wen0[k];
          m_addr[k] = m_g[k] ? addr1[k] : addr0[k];
          m_wd[k]   = m_g[k] ? wd1[k]   : wd0[k];
          m_e[k]    = 0;
          m_ph[k]   = 1;
        end
      end else if (m_ph[k] == 1) begin
        m_e[k] = m_e[k] + 1;
        if (m_e[k] == lat_of(k)) begin
          if (!m_wen[k]) begin
            if (m_g[k]) m_rd1[k] = brd[k];
            else        m_rd0[k] = brd[k];
          end
          m_ph[k] = 2;
        end
      end else begin
        m_last[k] = m_g[k];
        m_ph[k]   = 0;
      end
    end
  end

  task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat=%0d t=%0t got %h want %h",
               nm, lat_of(k), $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      cmp("ack0", k, 32'(ack0[k]), 32'(m_ph[k] == 2 && !m_g[k]));
      cmp("ack1", k, 32'(ack1[k]), 32'(m_ph[k] == 2 && m_g[k]));
      cmp("bus_wen", k, 32'(bwen[k]),
          32'(m_ph[k] == 1 && m_e[k] == 0 && m_wen[k]));
      cmp("bus_addr", k, baddr[k], m_addr[k]);
      cmp("bus_wdata", k, bwd[k], m_wd[k]);
      cmp("m0_rdata", k, rd0[k], m_rd0[k]);
      cmp("m1_rdata", k, rd1[k], m_rd1[k]);
      cmp("ack_excl", k, 32'(ack0[k] & ack1[k]), 32'd0);
    end
  endtask

  task automatic set_in(int k, logic r0, logic r1, logic w0, logic w1,
                        logic [31:0] a0, logic [31:0] a1,
                        logic [31:0] d0, logic [31:0] d1);
    req0[k] = r0; req1[k] = r1; wen0[k] = w0; wen1[k] = w1;
    addr0[k] = a0; addr1[k] = a1; wd0[k] = d0; wd1[k] = d1;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  // Masters hold req until their ack, occasionally drop early.
  task automatic rand_drive();
    for (int k = 0; k < NI; k++) begin
      brd[k] = $urandom;
      for (int m = 0; m < 2; m++) begin
        logic acked, cur, nr;
        acked = (m_ph[k] == 2) && (m_g[k] == m[0]);
        cur   = (m == 0) ? req0[k] : req1[k];
        if (acked || !cur) begin
          nr = acked ? 1'($urandom_range(0, 1))
                     : ($urandom_range(0, 2) == 0);
          if (m == 0) begin
            req0[k] = nr; wen0[k] = 1'($urandom_range(0, 1));
            addr0[k] = $urandom; wd0[k] = $urandom;
          end else begin
            req1[k] = nr; wen1[k] = 1'($urandom_range(0, 1));
            addr1[k] = $urandom; wd1[k] = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          if (m == 0) req0[k] = 1'b0;
          else        req1[k] = 1'b0;
        end
      end
    end
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d1, rd;
    logic        k0, k1, bw;
    logic [31:0] ad, wd, x0, x1;
  } vec_t;

  function automatic vec_t mk(logic r0, logic r1, logic w0, logic w1,
                              logic [31:0] a0, logic [31:0] a1,
                              logic [31:0] d1, logic [31:0] rd,
                              logic k0, logic k1, logic bw,
                              logic [31:0] ad, logic [31:0] wd,
                              logic [31:0] x0, logic [31:0] x1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d1 = d1; v.rd = rd;
    v.k0 = k0; v.k1 = k1; v.bw = bw;
    v.ad = ad; v.wd = wd; v.x0 = x0; v.x1 = x1;
    return v;
  endfunction

  vec_t tv[18];

  initial begin
    logic [31:0] R = 32'h1234_5678;
    logic [31:0] W = 32'hDEAD_BEEF;
    int first[NI];

    tv[0]  = mk(1,0,0,0,'h100,0,0,R,     0,0,0,'h100,0,0,0);
    tv[1]  = mk(1,0,0,0,'h100,0,0,R,     1,0,0,'h100,0,R,0);
    tv[2]  = mk(0,0,0,0,'h100,0,0,0,     0,0,0,'h100,0,R,0);
    tv[3]  = mk(0,1,0,1,0,'h200,W,0,     0,0,1,'h200,W,R,0);
    tv[4]  = mk(0,1,0,1,0,'h200,W,0,     0,1,0,'h200,W,R,0);
    tv[5]  = mk(0,0,0,0,0,'h200,0,0,     0,0,0,'h200,W,R,0);
    tv[6]  = mk(1,1,0,0,'h300,'h400,0,0,    0,0,0,'h300,0,R,0);
    tv[7]  = mk(1,1,0,0,'h300,'h400,0,'hA0, 1,0,0,'h300,0,'hA0,0);
    tv[8]  = mk(1,1,0,0,'h300,'h400,0,0,    0,0,0,'h300,0,'hA0,0);
    tv[9]  = mk(1,1,0,0,'h300,'h400,0,0,    0,0,0,'h400,0,'hA0,0);
    tv[10] = mk(1,1,0,0,'h300,'h400,0,'hB1, 0,1,0,'h400,0,'hA0,'hB1);
    tv[11] = mk(1,1,0,0,'h300,'h400,0,0,    0,0,0,'h400,0,'hA0,'hB1);
    tv[12] = mk(1,1,0,0,'h300,'h400,0,0,    0,0,0,'h300,0,'hA0,'hB1);
    tv[13] = mk(1,1,0,0,'h300,'h400,0,'hC2, 1,0,0,'h300,0,'hC2,'hB1);
    tv[14] = mk(1,1,0,0,'h300,'h400,0,0,    0,0,0,'h300,0,'hC2,'hB1);
    tv[15] = mk(1,1,0,0,'h300,'h400,0,0,    0,0,0,'h400,0,'hC2,'hB1);
    tv[16] = mk(1,1,0,0,'h300,'h400,0,'hD3, 0,1,0,'h400,0,'hC2,'hD3);
    tv[17] = mk(0,0,0,0,'h300,'h400,0,0,    0,0,0,'h400,0,'hC2,'hD3);

    for (int k = 0; k < NI; k++) begin
      set_in(k, 0, 0, 0, 0, 0, 0, 0, 0);
      brd[k] = '0;
    end

    repeat (2) @(negedge clk);
    check_all();
    for (int k = 0; k < NI; k++) begin
      cmp("rst_bus_addr", k, baddr[k], 32'd0);
      cmp("rst_rdata0", k, rd0[k], 32'd0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      set_in(0, tv[i].r0, tv[i].r1, tv[i].w0, tv[i].w1,
             tv[i].a0, tv[i].a1, 32'd0, tv[i].d1);
      brd[0] = tv[i].rd;
      tick();
      cmp($sformatf("tv%0d_ack0", i), 0, 32'(ack0[0]), 32'(tv[i].k0));
      cmp($sformatf("tv%0d_ack1", i), 0, 32'(ack1[0]), 32'(tv[i].k1));
      cmp($sformatf("tv%0d_wen", i), 0, 32'(bwen[0]), 32'(tv[i].bw));
      cmp($sformatf("tv%0d_addr", i), 0, baddr[0], tv[i].ad);
      cmp($sformatf("tv%0d_wdata", i), 0, bwd[0], tv[i].wd);
      cmp($sformatf("tv%0d_rd0", i), 0, rd0[0], tv[i].x0);
      cmp($sformatf("tv%0d_rd1", i), 0, rd1[0], tv[i].x1);
    end

    // LAT=3 read: data must come from the third busy cycle.
    set_in(1, 1, 0, 0, 0, 32'h500, 0, 0, 0);
    brd[1] = 32'hFFFF_0000;
    tick();
    req0[1] = 1'b0;
    brd[1] = 32'h1111_1111;
    tick();
    cmp("lat3_ack_c1", 1, 32'(ack0[1]), 32'd0);
    brd[1] = 32'h2222_2222;
    tick();
    cmp("lat3_ack_c2", 1, 32'(ack0[1]), 32'd0);
    brd[1] = 32'h3333_3333;
    tick();
    cmp("lat3_ack_c3", 1, 32'(ack0[1]), 32'd1);
    cmp("lat3_rdata", 1, rd0[1], 32'h3333_3333);
    brd[1] = 32'h0;
    tick();
    cmp("lat3_ack_end", 1, 32'(ack0[1]), 32'd0);

    // m1 releases req right after the grant.
    set_in(0, 0, 1, 0, 1, 0, 32'h600, 0, 32'h55AA_55AA);
    tick();
    cmp("early_wen", 0, 32'(bwen[0]), 32'd1);
    cmp("early_wdata", 0, bwd[0], 32'h55AA_55AA);
    req1[0] = 1'b0;
    tick();
    cmp("early_ack", 0, 32'(ack1[0]), 32'd1);
    tick();

    for (int c = 0; c < 3000; c++) begin
      rand_drive();
      tick();
    end

    for (int k = 0; k < NI; k++) set_in(k, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) tick();

    // Abort a LAT=3 write mid-access with an async reset.
    set_in(1, 0, 1, 0, 1, 0, 32'h700, 0, 32'hCAFE_F00D);
    tick();
    cmp("abort_wen", 1, 32'(bwen[1]), 32'd1);
    tick();
    #2 rst_n = 1'b0;
    #1 check_all();
    for (int k = 0; k < NI; k++) begin
      cmp("abort_addr", k, baddr[k], 32'd0);
      cmp("abort_wdata", k, bwd[k], 32'd0);
      cmp("abort_ack", k, 32'(ack0[k] | ack1[k]), 32'd0);
      cmp("abort_wen0", k, 32'(bwen[k]), 32'd0);
    end
    req1[1] = 1'b0;
    repeat (3) begin
      tick();
      cmp("abort_noack", 1, 32'(ack0[1] | ack1[1]), 32'd0);
    end
    for (int k = 0; k < NI; k++) begin
      set_in(k, 1, 1, 0, 0, 32'h800, 32'h900, 0, 0);
      first[k] = 2;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        if (first[k] == 2 && ack0[k]) first[k] = 0;
        if (first[k] == 2 && ack1[k]) first[k] = 1;
      end
    end
    for (int k = 0; k < NI; k++) begin
      cmp("post_rst_winner", k, 32'(first[k]), 32'd0);
      set_in(k, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
